// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA timing defaults (640x480 @ 60 Hz, 25 MHz pixel
//               clock), RGB565 pixel type and a few named colours.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Default 640x480 timing, in pixel clocks (horizontal) and lines (vertical)
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int DEF_H_VALID = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_V_VALID = 480;
  localparam int DEF_V_FRONT = 10;

  localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_VALID + DEF_H_FRONT;
  localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_VALID + DEF_V_FRONT;

  // Both raster counters are this wide; totals above 1024 do not fit
  localparam int CNT_W = 10;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam rgb565_t BLACK = '{r: 5'h00, g: 6'h00, b: 5'h00};
  localparam rgb565_t WHITE = '{r: 5'h1F, g: 6'h3F, b: 5'h1F};
  localparam rgb565_t RED   = '{r: 5'h1F, g: 6'h00, b: 5'h00};
  localparam rgb565_t GREEN = '{r: 5'h00, g: 6'h3F, b: 5'h00};
  localparam rgb565_t BLUE  = '{r: 5'h00, g: 6'h00, b: 5'h1F};

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_timing_cnt.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_cnt
// Description : Horizontal / vertical raster position counters. h_cnt runs
//               0..H_TOTAL-1 every clock; v_cnt advances once per line and
//               wraps together with h_cnt at the end of the frame.
// Ports       : clk    in  pixel clock
//               rst    in  synchronous active-high reset
//               h_cnt  out current column within the full line
//               v_cnt  out current line within the full frame
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_cnt
  import vga_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt
);

  localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_h_wrap;
  logic             w_v_wrap;

  assign w_h_wrap = (r_h_cnt == C_H_LAST);
  assign w_v_wrap = (r_v_cnt == C_V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      // The line counter only moves at the end of a line
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign h_cnt = r_h_cnt;
  assign v_cnt = r_v_cnt;

endmodule : vga_timing_cnt
`default_nettype wire

// File: rtl/vga_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_ctrl
// Description : VGA timing generator with a pixel-request interface. Every
//               output is registered from the raster counters of the previous
//               clock. Pixel requests lead active video by two clocks so a
//               generator with a fixed one-clock latency lines up with de.
// Ports       : clk          in   pixel clock
//               rst          in   synchronous active-high reset
//               pix_data     in   RGB565 answer to the previous request
//               pix_req      out  pixel request strobe
//               pix_x/pix_y  out  requested coordinate (held when idle)
//               hsync/vsync  out  sync pulses, asserted level SYNC_POL
//               de           out  active-video enable, aligned with rgb
//               rgb          out  RGB565 pixel, black outside active video
//               frame_start  out  one-clock pulse at raster origin
// Revision    : 1.0 - initial release
// ============================================================================
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   H_VALID  = DEF_H_VALID,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter int   V_VALID  = DEF_V_VALID,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pix_data,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam int C_H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int C_V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  // Window boundaries as counter-width constants (end values are exclusive)
  localparam logic [CNT_W-1:0] C_H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] C_V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] C_HA         = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] C_HA_END     = CNT_W'(H_SYNC + H_BACK + H_VALID);
  localparam logic [CNT_W-1:0] C_VA         = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] C_VA_END     = CNT_W'(V_SYNC + V_BACK + V_VALID);
  // Requests run two columns ahead of the visible window: one clock for the
  // generator, one for the rgb output register.
  localparam logic [CNT_W-1:0] C_REQ_BEG    = CNT_W'(H_SYNC + H_BACK - 2);
  localparam logic [CNT_W-1:0] C_REQ_END    = CNT_W'(H_SYNC + H_BACK + H_VALID - 2);

  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;

  vga_timing_cnt #(
    .H_TOTAL (C_H_TOTAL),
    .V_TOTAL (C_V_TOTAL)
  ) u_timing_cnt (
    .clk   (clk),
    .rst   (rst),
    .h_cnt (w_h_cnt),
    .v_cnt (w_v_cnt)
  );

  // --------------------------------------------------------------------------
  // Raster decode (current counter state)
  // --------------------------------------------------------------------------
  logic w_h_sync;
  logic w_v_sync;
  logic w_h_act;
  logic w_v_act;
  logic w_h_req;
  logic w_de;
  logic w_req;
  logic w_origin;

  assign w_h_sync = (w_h_cnt < C_H_SYNC_END);
  assign w_v_sync = (w_v_cnt < C_V_SYNC_END);
  assign w_h_act  = (w_h_cnt >= C_HA)      && (w_h_cnt < C_HA_END);
  assign w_v_act  = (w_v_cnt >= C_VA)      && (w_v_cnt < C_VA_END);
  assign w_h_req  = (w_h_cnt >= C_REQ_BEG) && (w_h_cnt < C_REQ_END);
  assign w_de     = w_h_act && w_v_act;
  assign w_req    = w_h_req && w_v_act;
  assign w_origin = (w_h_cnt == '0) && (w_v_cnt == '0);

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  logic        r_hsync;
  logic        r_vsync;
  logic        r_de;
  logic [15:0] r_rgb;
  logic        r_pix_req;
  logic [9:0]  r_pix_x;
  logic [9:0]  r_pix_y;
  logic        r_frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_de          <= 1'b0;
      r_rgb         <= BLACK;
      r_pix_req     <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_h_sync ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_v_sync ? SYNC_POL : ~SYNC_POL;
      r_de          <= w_de;
      // pix_data already answers the request issued two columns earlier
      r_rgb         <= w_de ? pix_data : BLACK;
      r_pix_req     <= w_req;
      r_frame_start <= w_origin;
      // Coordinates hold between requests so an idle generator sees no change
      if (w_req) begin
        r_pix_x <= w_h_cnt - C_REQ_BEG;
        r_pix_y <= w_v_cnt - C_VA;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign rgb         = r_rgb;
  assign pix_req     = r_pix_req;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign frame_start = r_frame_start;

endmodule : vga_ctrl
`default_nettype wire

// File: tb/tb_vga_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_ctrl
// Description : Self-checking bench for vga_ctrl on a reduced raster
//               (17 x 11 clocks per frame). A generator model answers pixel
//               requests; requested pixels are queued as expected rgb values
//               and a negedge monitor pops them whenever de is high, while also
//               checking sync, request and frame timing against the raster
//               offset since the last frame origin.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_ctrl;

  // Reduced timing. Hand-derived: line = 4+3+8+2 = 17, frame lines = 2+3+4+2 = 11
  localparam int HS    = 4;
  localparam int HB    = 3;
  localparam int HV    = 8;
  localparam int HF    = 2;
  localparam int VS    = 2;
  localparam int VB    = 3;
  localparam int VV    = 4;
  localparam int VF    = 2;
  localparam int HT    = 17;
  localparam int FRAME = 187;  // 17 * 11
  localparam int HA    = 7;    // first visible column
  localparam int VA    = 5;    // first visible line
  localparam int PIX_PER_FRAME = 32;  // 8 * 4
  localparam int MID_T   = 112;  // column 10, line 6: inside active video
  localparam int BLANK_T = 160;  // line 9: vertical front porch, queue empty

  bit          clk;
  logic        rst;
  logic [15:0] pix_data = 16'h0000;
  logic        pix_req;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [15:0] rgb;
  logic        frame_start;

  vga_ctrl #(
    .H_SYNC   (HS),
    .H_BACK   (HB),
    .H_VALID  (HV),
    .H_FRONT  (HF),
    .V_SYNC   (VS),
    .V_BACK   (VB),
    .V_VALID  (VV),
    .V_FRONT  (VF),
    .SYNC_POL (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_data    (pix_data),
    .pix_req     (pix_req),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Generator model: one-clock latency answer to each request
  bit force_ff = 1'b0;
  always @(posedge clk) begin
    if (force_ff)
      pix_data <= 16'hFFFF;
    else if (pix_req)
      pix_data <= {6'b0, pix_x};
  end

  // Reset seen at the last active edge
  bit rst_seen = 1'b0;
  bit started  = 1'b0;
  always @(posedge clk) begin
    rst_seen <= rst;
    started  <= 1'b1;
  end

  // Scoreboard / monitor state
  logic [15:0] exp_q[$];
  int          t = -1;
  int          h;
  int          v;
  logic [9:0]  rq_x;
  logic [9:0]  rq_y;
  logic [9:0]  held_x;
  logic [9:0]  held_y;
  int          n_req;
  int          n_de;
  logic        e_hs;
  logic        e_vs;
  logic        e_de;
  logic        e_req;
  logic [15:0] e_rgb;

  always @(negedge clk) begin
    if (started) begin
      if (rst_seen) begin
        check("rst_hsync", {15'b0, hsync}, 16'd1);
        check("rst_vsync", {15'b0, vsync}, 16'd1);
        check("rst_de", {15'b0, de}, 16'd0);
        check("rst_pix_req", {15'b0, pix_req}, 16'd0);
        check("rst_frame_start", {15'b0, frame_start}, 16'd0);
        check("rst_rgb", rgb, 16'h0000);
        check("rst_pix_x", {6'b0, pix_x}, 16'd0);
        check("rst_pix_y", {6'b0, pix_y}, 16'd0);
        t      = -1;
        rq_x   = '0;
        rq_y   = '0;
        held_x = '0;
        held_y = '0;
        n_req  = 0;
        n_de   = 0;
        exp_q.delete();
      end else begin
        t = (t + 1) % FRAME;
        h = t % HT;
        v = t / HT;
        e_hs  = !(h < HS);
        e_vs  = !(v < VS);
        e_de  = (h >= HA) && (h < HA + HV) && (v >= VA) && (v < VA + VV);
        e_req = (h >= HA - 2) && (h < HA + HV - 2) && (v >= VA) && (v < VA + VV);
        check("frame_start", {15'b0, frame_start}, {15'b0, (t == 0)});
        check("hsync", {15'b0, hsync}, {15'b0, e_hs});
        check("vsync", {15'b0, vsync}, {15'b0, e_vs});
        check("de", {15'b0, de}, {15'b0, e_de});
        check("pix_req", {15'b0, pix_req}, {15'b0, e_req});

        if (pix_req) begin
          check("pix_x", {6'b0, pix_x}, {6'b0, rq_x});
          check("pix_y", {6'b0, pix_y}, {6'b0, rq_y});
          exp_q.push_back(force_ff ? 16'hFFFF : {6'b0, rq_x});
          held_x = rq_x;
          held_y = rq_y;
          n_req++;
          if (rq_x == 10'(HV - 1)) begin
            rq_x = '0;
            rq_y = (rq_y == 10'(VV - 1)) ? '0 : rq_y + 1'b1;
          end else begin
            rq_x = rq_x + 1'b1;
          end
        end else begin
          check("pix_x_hold", {6'b0, pix_x}, {6'b0, held_x});
          check("pix_y_hold", {6'b0, pix_y}, {6'b0, held_y});
        end

        if (de) begin
          n_de++;
          if (exp_q.size() == 0) begin
            check("rgb_no_pending_pixel", rgb, 16'hDEAD);
          end else begin
            e_rgb = exp_q.pop_front();
            check("rgb_active", rgb, e_rgb);
          end
        end else begin
          check("rgb_blank", rgb, 16'h0000);
        end

        if (t == FRAME - 1) begin
          check("req_per_frame", 16'(n_req), 16'(PIX_PER_FRAME));
          check("de_per_frame", 16'(n_de), 16'(PIX_PER_FRAME));
          n_req = 0;
          n_de  = 0;
        end
      end
    end
  end

  // Wait (bounded) until the monitor's raster offset reaches target
  task automatic wait_offset(input int target, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      #1;
      if (t == target) found = 1'b1;
    end
    check(name, {15'b0, found}, 16'd1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // Two full frames of free-running timing and model-generated pixels
    repeat (2 * FRAME + 20) @(negedge clk);

    // One-clock reset in the middle of active video, then a full frame
    wait_offset(MID_T, "wait_mid_frame");
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (FRAME + 10) @(negedge clk);

    // Constant all-ones generator for a full frame, switched during blanking
    wait_offset(BLANK_T, "wait_blank_a");
    force_ff = 1'b1;
    repeat (FRAME + 10) @(negedge clk);
    wait_offset(BLANK_T, "wait_blank_b");

    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_vga_ctrl
`default_nettype wire
